// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared defaults and helpers for the ROM arbiter.
// Optional round-robin arbitration is enabled by defining ROM_ARB_RR_EN.
package rom_arb_pkg;

    localparam int D_DEF    = 8;
    localparam int A_DEF    = 14;
    localparam int NREQ_DEF = 3;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // Returns an 8-bit one-hot vector; callers size it down to NREQ.
    function automatic logic [7:0] onehot(input int idx, input int n);
        return (idx < n) ? 8'(1) << idx : 8'h00;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester-side bus of the ROM arbiter.
// master = requester side, slave = arbiter side.
interface rom_arbiter_if import rom_arb_pkg::*; #(
    parameter int D    = D_DEF,
    parameter int A    = A_DEF,
    parameter int NREQ = NREQ_DEF
) ();

    logic [NREQ-1:0]   req;
    logic [NREQ*A-1:0] addr;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   valid;
    logic [D-1:0]      rdata;
    logic              busy;

    modport master (
        output req, addr,
        input  ack, valid, rdata, busy
    );

    modport slave (
        input  req, addr,
        output ack, valid, rdata, busy
    );

endinterface

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: rotating priority encoder; the first set req at or after start wins.
// Fixed-priority operation is simply start = 0.
module rom_arb_pick import rom_arb_pkg::*; #(
    parameter  int NREQ = NREQ_DEF,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            any,
    output logic [IW-1:0]   win
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IW-1:0]     ofs;
    logic [IW:0]       sum;

    // Rotate req so that bit 0 is the start position, then take the lowest set bit.
    always_comb begin
        dbl = {req, req} >> start;
        rot = dbl[NREQ-1:0];
        ofs = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            ofs = rot[i] ? IW'(i) : ofs;
        sum = {1'b0, start} + {1'b0, ofs};
        win = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
        any = |req;
    end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one registered-output ROM among NREQ requesters, one read per cycle.
// Define ROM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module rom_arbiter import rom_arb_pkg::*; #(
    parameter int D    = D_DEF,
    parameter int A    = A_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic           clock,
    input  logic           reset,
    rom_arbiter_if.slave   bus,
    output logic [A-1:0]   rom_a,
    input  logic [D-1:0]   rom_do
);

    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0] req_g;
    logic            any;
    logic [IW-1:0]   win;
    logic [IW-1:0]   start;
    logic [A-1:0]    sel_a;
    logic [A-1:0]    last_a;
    logic            vld_q;
    logic [IW-1:0]   gid_q;

    assign req_g = reset ? '0 : bus.req;

`ifdef ROM_ARB_RR_EN
    logic [IW-1:0] ptr;

    // Unused codes fall back to a search starting at index 0, like ptr = NREQ-1.
    assign start = (ptr >= IW'(NREQ - 1)) ? '0 : ptr + IW'(1);

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= IW'(NREQ - 1);
        else if (any)
            ptr <= win;
    end
`else
    assign start = '0;
`endif

    rom_arb_pick #(.NREQ(NREQ)) pick (
        .req   (req_g),
        .start (start),
        .any   (any),
        .win   (win)
    );

    always_comb begin
        sel_a     = bus.addr[win*A +: A];
        rom_a     = reset ? '0 : (any ? sel_a : last_a);
        bus.ack   = any ? NREQ'(onehot(int'(win), NREQ)) : '0;
        bus.valid = (vld_q && !reset) ? NREQ'(onehot(int'(gid_q), NREQ)) : '0;
        bus.busy  = |bus.valid;
        bus.rdata = rom_do;
    end

    // The in-flight read is dropped by reset; the valid gate above covers the reset cycle itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= 1'b0;
            gid_q  <= '0;
            last_a <= '0;
        end else begin
            vld_q <= any;
            if (any) begin
                gid_q  <= win;
                last_a <= sel_a;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: vector table, contention sequence and random handshake traffic vs a reference model.
// Expectations follow ROM_ARB_RR_EN the same way the design does.
module tb_rom_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [13:0] rom_a;
    logic [7:0]  rom_do;

    rom_arbiter_if #(.D(8), .A(14), .NREQ(3)) bus ();

    rom_arbiter #(.D(8), .A(14), .NREQ(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .rom_a  (rom_a),
        .rom_do (rom_do)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] rom_fn(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01} ^ 8'h5A;
    endfunction

    always @(posedge clock) rom_do <= rom_fn(rom_a);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: last winner, the pending read, and the held address.
    int          m_ptr = 2;
    bit          m_vld = 0;
    int          m_gid = 0;
    logic [13:0] m_daddr = '0;
    logic [13:0] m_last_a = '0;
    int          last_w;

    logic [2:0]  s_ack, s_valid;
    logic [13:0] s_rom_a;
    logic        s_busy;

    function automatic int m_pick(input logic [2:0] rq);
        if (rq == 3'b000) return -1;
`ifdef ROM_ARB_RR_EN
        for (int k = 1; k <= 3; k++)
            if (rq[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
`else
        for (int j = 0; j < 3; j++)
            if (rq[j]) return j;
`endif
        return -1;
    endfunction

    task automatic cyc(input logic r, input logic [2:0] rq,
                       input logic [13:0] a0, input logic [13:0] a1, input logic [13:0] a2);
        logic [13:0] av [3];
        logic [2:0]  e_ack, e_valid;
        logic [13:0] e_rom_a;
        int          w;
        av[0] = a0; av[1] = a1; av[2] = a2;
        reset    = r;
        bus.req  = rq;
        bus.addr = {a2, a1, a0};
        #3;
        s_ack   = bus.ack;
        s_valid = bus.valid;
        s_rom_a = rom_a;
        s_busy  = bus.busy;
        w       = r ? -1 : m_pick(rq);
        e_ack   = (w >= 0) ? 3'(1 << w) : 3'b000;
        e_valid = (!r && m_vld) ? 3'(1 << m_gid) : 3'b000;
        e_rom_a = r ? 14'h0 : ((w >= 0) ? av[w] : m_last_a);
        chk("model_ack", s_ack, e_ack);
        chk("model_valid", s_valid, e_valid);
        chk("model_rom_a", s_rom_a, e_rom_a);
        chk("model_busy", s_busy, |e_valid);
        if (e_valid != 3'b000) chk("model_rdata", bus.rdata, rom_fn(m_daddr));
        last_w = w;
        if (r) begin
            m_vld = 0; m_last_a = '0; m_ptr = 2;
        end else begin
            m_vld = (w >= 0);
            if (w >= 0) begin
                m_gid = w; m_daddr = av[w]; m_last_a = av[w]; m_ptr = w;
            end
        end
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [2:0]  rq;
        logic [13:0] a0, a1, a2;
        logic [2:0]  ack, valid;
        logic [13:0] rom_a;
        logic        busy;
    } vec_t;

    vec_t        tv [17];
    logic [2:0]  cs [4];
    logic [13:0] ra [3];
    bit          pend [3];
    int          waitc [3];
    int          maxw = 0;
    bit          r;

    initial begin
        tv[0]  = '{1, 3'b111, 14'h5,    14'h6,    14'h7,    3'b000, 3'b000, 14'h0,    0};
        tv[1]  = '{0, 3'b001, 14'h0,    14'h0,    14'h0,    3'b001, 3'b000, 14'h0,    0};
        tv[2]  = '{0, 3'b000, 14'h0,    14'h0,    14'h0,    3'b000, 3'b001, 14'h0,    1};
        tv[3]  = '{0, 3'b001, 14'h10,   14'h0,    14'h0,    3'b001, 3'b000, 14'h10,   0};
        tv[4]  = '{0, 3'b001, 14'h11,   14'h0,    14'h0,    3'b001, 3'b001, 14'h11,   1};
        tv[5]  = '{0, 3'b001, 14'h12,   14'h0,    14'h0,    3'b001, 3'b001, 14'h12,   1};
        tv[6]  = '{0, 3'b001, 14'h13,   14'h0,    14'h0,    3'b001, 3'b001, 14'h13,   1};
        tv[7]  = '{0, 3'b000, 14'h0,    14'h0,    14'h0,    3'b000, 3'b001, 14'h13,   1};
        tv[8]  = '{0, 3'b000, 14'h0,    14'h0,    14'h0,    3'b000, 3'b000, 14'h13,   0};
        tv[9]  = '{0, 3'b100, 14'h0,    14'h0,    14'h3FFF, 3'b100, 3'b000, 14'h3FFF, 0};
        tv[10] = '{0, 3'b000, 14'h0,    14'h0,    14'h0,    3'b000, 3'b100, 14'h3FFF, 1};
        tv[11] = '{0, 3'b000, 14'h0,    14'h0,    14'h0,    3'b000, 3'b000, 14'h3FFF, 0};
        tv[12] = '{0, 3'b000, 14'h0,    14'h0,    14'h0,    3'b000, 3'b000, 14'h3FFF, 0};
        tv[13] = '{0, 3'b010, 14'h0,    14'h0ABC, 14'h0,    3'b010, 3'b000, 14'h0ABC, 0};
        tv[14] = '{1, 3'b111, 14'h1,    14'h2,    14'h3,    3'b000, 3'b000, 14'h0,    0};
        tv[15] = '{0, 3'b111, 14'h100,  14'h200,  14'h300,  3'b001, 3'b000, 14'h100,  0};
        tv[16] = '{0, 3'b000, 14'h0,    14'h0,    14'h0,    3'b000, 3'b001, 14'h100,  1};
`ifdef ROM_ARB_RR_EN
        cs[0] = 3'b001; cs[1] = 3'b010; cs[2] = 3'b100; cs[3] = 3'b001;
`else
        cs[0] = 3'b001; cs[1] = 3'b001; cs[2] = 3'b001; cs[3] = 3'b001;
`endif
        reset    = 1'b1;
        bus.req  = '0;
        bus.addr = '0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 17; i++) begin
            cyc(tv[i].r, tv[i].rq, tv[i].a0, tv[i].a1, tv[i].a2);
            chk($sformatf("tv%0d_ack", i), s_ack, tv[i].ack);
            chk($sformatf("tv%0d_valid", i), s_valid, tv[i].valid);
            chk($sformatf("tv%0d_rom_a", i), s_rom_a, tv[i].rom_a);
            chk($sformatf("tv%0d_busy", i), s_busy, tv[i].busy);
        end

        // Full contention right after reset.
        cyc(1, 3'b000, 14'h0, 14'h0, 14'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 3'b111, 14'h20, 14'h21, 14'h22);
            chk($sformatf("cont%0d_ack", k), s_ack, cs[k]);
            chk($sformatf("cont%0d_valid", k), s_valid, (k == 0) ? 3'b000 : cs[k-1]);
        end
        cyc(0, 3'b000, 14'h0, 14'h0, 14'h0);
        chk("cont_tail_valid", s_valid, cs[3]);

        // Random requesters that hold req/addr until acked.
        for (int i = 0; i < 3; i++) begin pend[i] = 0; waitc[i] = 0; end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++)
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1; ra[i] = 14'($urandom); waitc[i] = 0;
                end
            r = ($urandom_range(39, 0) == 0);
            cyc(r, {pend[2], pend[1], pend[0]}, ra[0], ra[1], ra[2]);
            for (int i = 0; i < 3; i++)
                if (pend[i] && !r) begin
                    if (last_w == i) pend[i] = 0;
                    else begin
                        waitc[i]++;
                        if (waitc[i] > maxw) maxw = waitc[i];
                    end
                end
        end
`ifdef ROM_ARB_RR_EN
        chk("rr_starvation_bound", maxw <= 2, 1);
`endif
        cyc(0, 3'b000, 14'h0, 14'h0, 14'h0);
        cyc(0, 3'b000, 14'h0, 14'h0, 14'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
